// File: rtl/load_seq_arbiter.sv
// Purpose : arbitrates add/remove requests onto one 3-bit saturating load
//           counter, drives its X/P controls and keeps a checked shadow count.
// Latency : grant at edge n, cnt_p high after edge n+1, ack high after edge n+3.
// Backpressure: level requests held until ack/nak; refused at full/empty with a nak.
//
// Ports:
//   w_clk, reset         clock; asynchronous active-high reset
//   req_add / req_rem    level requests (sampled only in IDLE)
//   ack_* / nak_*        one-cycle completion / refusal pulses
//   cnt_x, cnt_p         counter direction (1=up) and step enable
//   cnt_q                counter Q feedback, checked in CHECK
//   count, full, empty   shadow count and its full/empty flags
//   busy, err            FSM-not-idle; sticky feedback mismatch flag
//
// Build option: define LOAD_RESYNC_EN to reload the shadow count from cnt_q
// when a feedback mismatch is seen (err is set either way).
module load_seq_arbiter #(
  parameter int CNT_W     = 3,
  parameter int MAX_COUNT = 7   // must equal 2**CNT_W-1
) (
  input  logic             w_clk,
  input  logic             reset,
  input  logic             req_add,
  input  logic             req_rem,
  output logic             ack_add,
  output logic             ack_rem,
  output logic             nak_add,
  output logic             nak_rem,
  output logic             cnt_x,
  output logic             cnt_p,
  input  logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, STEP, CHECK} state_t;
  typedef enum logic {GRANT_REM, GRANT_ADD} grant_t;

  state_t           state_q, state_d;
  grant_t           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cnt_x_q, cnt_x_d;
  logic             cnt_p_q, cnt_p_d;
  logic             ack_add_q, ack_add_d;
  logic             ack_rem_q, ack_rem_d;
  logic             nak_add_q, nak_add_d;
  logic             nak_rem_q, nak_rem_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             add_ok, rem_ok;

  assign full  = (count_q == MAX_C);
  assign empty = (count_q == '0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    cnt_x_d      = cnt_x_q;
    cnt_p_d      = 1'b0;
    ack_add_d    = 1'b0;
    ack_rem_d    = 1'b0;
    nak_add_d    = 1'b0;
    nak_rem_d    = 1'b0;
    err_d        = err_q;
    add_ok       = req_add & ~full;
    rem_ok       = req_rem & ~empty;

    case (state_q)
      IDLE: begin
        // A refused request that is still held is refused again every other
        // cycle, giving the requester one cycle to see the nak and drop.
        nak_add_d = req_add & full  & ~nak_add_q;
        nak_rem_d = req_rem & empty & ~nak_rem_q;
        if (add_ok && (!rem_ok || last_grant_q == GRANT_REM)) begin
          cnt_x_d      = 1'b1;
          last_grant_d = GRANT_ADD;
          state_d      = SETUP;
        end else if (rem_ok) begin
          cnt_x_d      = 1'b0;
          last_grant_d = GRANT_REM;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        // X has been stable for a full cycle; enable the step next cycle.
        cnt_p_d = 1'b1;
        state_d = STEP;
      end
      STEP: begin
        // Eligibility in IDLE already excludes these ends; the guard keeps the
        // shadow from wrapping even if that ever changes.
        if (cnt_x_q && count_q != MAX_C) begin
          count_d = count_q + ONE_C;
        end else if (!cnt_x_q && count_q != '0) begin
          count_d = count_q - ONE_C;
        end
        state_d = CHECK;
      end
      CHECK: begin
        if (cnt_q != count_q) begin
          err_d = 1'b1;
`ifdef LOAD_RESYNC_EN
          count_d = cnt_q;
`else
          count_d = count_q;
`endif
        end
        ack_add_d = cnt_x_q;
        ack_rem_d = ~cnt_x_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_REM;
      count_q      <= '0;
      cnt_x_q      <= 1'b0;
      cnt_p_q      <= 1'b0;
      ack_add_q    <= 1'b0;
      ack_rem_q    <= 1'b0;
      nak_add_q    <= 1'b0;
      nak_rem_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      cnt_x_q      <= cnt_x_d;
      cnt_p_q      <= cnt_p_d;
      ack_add_q    <= ack_add_d;
      ack_rem_q    <= ack_rem_d;
      nak_add_q    <= nak_add_d;
      nak_rem_q    <= nak_rem_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign ack_add = ack_add_q;
  assign ack_rem = ack_rem_q;
  assign nak_add = nak_add_q;
  assign nak_rem = nak_rem_q;
  assign cnt_x   = cnt_x_q;
  assign cnt_p   = cnt_p_q;
  assign count   = count_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_load_seq_arbiter.sv
// Purpose : self-checking bench for load_seq_arbiter with a saturating
//           counter model on cnt_q and an edge-indexed reference model.
// Latency / backpressure: checks every output one time unit after each edge.
`timescale 1ns/1ps
module tb_load_seq_arbiter;

  localparam int CNT_W     = 3;
  localparam int MAX_COUNT = 7;

  logic             w_clk = 1'b0;
  logic             reset;
  logic             req_add, req_rem;
  logic             ack_add, ack_rem, nak_add, nak_rem;
  logic             cnt_x, cnt_p;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] count;
  logic             full, empty, busy, err;

  always #5 w_clk = ~w_clk;

  load_seq_arbiter #(.CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT)) dut (
    .w_clk   (w_clk),
    .reset   (reset),
    .req_add (req_add),
    .req_rem (req_rem),
    .ack_add (ack_add),
    .ack_rem (ack_rem),
    .nak_add (nak_add),
    .nak_rem (nak_rem),
    .cnt_x   (cnt_x),
    .cnt_p   (cnt_p),
    .cnt_q   (cnt_q),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .err     (err)
  );

  int vec_cnt = 0;
  int mis_cnt = 0;

  // Reference model: a transaction is described by the edge it was granted
  // on; everything else follows from the distance to that edge.
  int edge_no = 0;
  int g_edge;
  int next_eval;
  bit g_add;
  bit last_add;
  int m_count;
  bit m_err;
  bit e_ack_add, e_ack_rem, e_nak_add, e_nak_rem, e_x, e_p, e_busy;

  int n_p = 0, n_ack_add = 0, n_ack_rem = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    g_edge    = -100;
    next_eval = 0;
    g_add     = 1'b0;
    last_add  = 1'b0;
    m_count   = 0;
    m_err     = 1'b0;
    e_ack_add = 0; e_ack_rem = 0; e_nak_add = 0; e_nak_rem = 0;
    e_x = 0; e_p = 0; e_busy = 0;
  endtask

  task automatic model_edge(input bit a, input bit r, input int q);
    int d;
    bit add_ok, rem_ok, na, nr;
    d = edge_no - g_edge;
    na = 0; nr = 0;
    e_ack_add = 0; e_ack_rem = 0;
    if (edge_no >= next_eval) begin
      add_ok = a && (m_count < MAX_COUNT);
      rem_ok = r && (m_count > 0);
      na = a && (m_count == MAX_COUNT) && !e_nak_add;
      nr = r && (m_count == 0) && !e_nak_rem;
      if (add_ok || rem_ok) begin
        g_add     = add_ok && (!rem_ok || !last_add);
        last_add  = g_add;
        g_edge    = edge_no;
        next_eval = edge_no + 4;
        e_x       = g_add;
      end
    end else if (d == 2) begin
      m_count = g_add ? m_count + 1 : m_count - 1;
    end else if (d == 3) begin
      if (q != m_count) begin
        m_err = 1'b1;
`ifdef LOAD_RESYNC_EN
        m_count = q;
`endif
      end
      e_ack_add = g_add;
      e_ack_rem = !g_add;
    end
    e_nak_add = na;
    e_nak_rem = nr;
    d = edge_no - g_edge;
    e_p    = (d == 1);
    e_busy = (d >= 0 && d <= 2);
  endtask

  task automatic compare_all();
    chk("ack_add", ack_add, e_ack_add);
    chk("ack_rem", ack_rem, e_ack_rem);
    chk("nak_add", nak_add, e_nak_add);
    chk("nak_rem", nak_rem, e_nak_rem);
    chk("cnt_x",   cnt_x,   e_x);
    chk("cnt_p",   cnt_p,   e_p);
    chk("count",   count,   m_count);
    chk("full",    full,    m_count == MAX_COUNT);
    chk("empty",   empty,   m_count == 0);
    chk("busy",    busy,    e_busy);
    chk("err",     err,     m_err);
  endtask

  // One clock: capture pre-edge inputs, step the counter model, step the
  // reference model, then compare.
  task automatic tick();
    logic a, r, p, x, rs;
    logic [CNT_W-1:0] q;
    a = req_add; r = req_rem; q = cnt_q; p = cnt_p; x = cnt_x; rs = reset;
    @(posedge w_clk);
    #1;
    edge_no++;
    if (rs) begin
      cnt_q = '0;
      model_reset();
    end else begin
      if (p === 1'b1) begin
        if (x && cnt_q != 3'd7) cnt_q = cnt_q + 3'd1;
        else if (!x && cnt_q != 3'd0) cnt_q = cnt_q - 3'd1;
      end
      model_edge(a, r, int'(q));
    end
    if (ack_add === 1'b1) n_ack_add++;
    if (ack_rem === 1'b1) n_ack_rem++;
    if (cnt_p === 1'b1) n_p++;
    compare_all();
  endtask

  task automatic sync_reset();
    req_add = 0; req_rem = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    cnt_q = '0;
    model_reset();
    chk("arst_cnt_p", cnt_p, 0);
    chk("arst_busy",  busy,  0);
    chk("arst_count", count, 0);
    compare_all();
    tick();
    reset = 1'b0;
  endtask

  // Raise one request, hold until its ack, drop; checks 4-cycle latency.
  task automatic do_op(input bit add);
    int lat;
    lat = 0;
    if (add) req_add = 1'b1; else req_rem = 1'b1;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if ((add ? ack_add : ack_rem) === 1'b1) lat = i;
    end
    req_add = 1'b0; req_rem = 1'b0;
    chk(add ? "add_ack_latency" : "rem_ack_latency", lat, 4);
  endtask

  initial begin
    int p0, a0, k;
    bit kinds[$];
    int cnts[$];
    reset = 1'b1; req_add = 0; req_rem = 0; cnt_q = '0;
    model_reset();

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();

    // Fill to full: 7 adds, 7 single-cycle steps
    p0 = n_p; a0 = n_ack_add;
    for (int i = 0; i < 7; i++) do_op(1'b1);
    chk("fill_steps", n_p - p0, 7);
    chk("fill_acks",  n_ack_add - a0, 7);
    chk("fill_count", count, 7);
    chk("fill_full",  full, 1);
    chk("fill_err",   err, 0);

    // Add at full is refused, held request refused again two cycles later
    p0 = n_p;
    req_add = 1'b1;
    tick(); chk("nak_full_1", nak_add, 1);
    tick(); chk("nak_full_gap", nak_add, 0);
    tick(); chk("nak_full_2", nak_add, 1);
    req_add = 1'b0;
    tick();
    chk("nak_no_step", n_p - p0, 0);
    chk("nak_count", count, 7);
    do_op(1'b0);
    chk("rem_after_full", count, 6);

    // Round robin at count 3
    do_op(1'b0); do_op(1'b0); do_op(1'b0);
    chk("rr_start", count, 3);
    req_add = 1'b1; req_rem = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ack_add === 1'b1 || ack_rem === 1'b1) begin
        kinds.push_back(ack_add);
        cnts.push_back(int'(count));
      end
    end
    req_add = 1'b0; req_rem = 1'b0;
    tick();
    chk("rr_n", kinds.size(), 4);
    for (int i = 0; i < 4 && i < kinds.size(); i++) begin
      chk("rr_kind",  kinds[i], (i % 2 == 0) ? 1 : 0);
      chk("rr_count", cnts[i],  (i % 2 == 0) ? 4 : 3);
    end

    // Empty: remove refused; then both held -> add first
    sync_reset();
    p0 = n_p;
    req_rem = 1'b1;
    tick(); chk("nak_empty", nak_rem, 1);
    req_rem = 1'b0;
    tick();
    chk("nak_empty_no_step", n_p - p0, 0);
    chk("nak_empty_count", count, 0);
    req_add = 1'b1; req_rem = 1'b1;
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      tick();
      if (ack_add === 1'b1) k = i;
    end
    req_add = 1'b0; req_rem = 1'b0;
    chk("tie_first_add", k, 4);
    chk("tie_count", count, 1);

    // Reset during STEP at count 2
    do_op(1'b1);
    chk("pre_abort_count", count, 2);
    req_add = 1'b1;
    tick(); tick();
    chk("in_step", cnt_p, 1);
    req_add = 1'b0;
    a0 = n_ack_add;
    async_reset();
    tick(); tick(); tick(); tick();
    chk("abort_no_ack", n_ack_add - a0, 0);

    // Feedback mismatch in CHECK: shadow 3, counter 5
    do_op(1'b1); do_op(1'b1);
    req_add = 1'b1;
    tick(); tick(); tick();
    chk("in_check_count", count, 3);
    cnt_q = 3'd5;
    tick();
    req_add = 1'b0;
    chk("mismatch_err", err, 1);
    tick();
`ifdef LOAD_RESYNC_EN
    chk("mismatch_count", count, 5);
`else
    chk("mismatch_count", count, 3);
`endif
    tick(); tick(); tick();
    chk("err_sticky", err, 1);

    // Randomized traffic with occasional resets and feedback upsets
    sync_reset();
    for (int i = 0; i < 3000; i++) begin
      req_add = ($urandom_range(0, 99) < 45);
      req_rem = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 499) == 0) cnt_q = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick();
    end
    req_add = 1'b0; req_rem = 1'b0;
    tick(); tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/load_seq_arbiter.md
Name: load_seq_arbiter

Overview:
- Sequences the 3-bit saturating load counter, which steps up on X=1 and down on X=0 at each enabled clock edge.
- Shares the counter between two requesters: an add port (item loaded) and a remove port (item unloaded).
- Generates the counter's X/P controls and keeps a shadow count, so that adds are never issued at full and removes never at empty.
- Checks the counter's Q feedback after every step.

Parameters:
- CNT_W, 3, width of count and of the counter feedback.
- MAX_COUNT, 7, count value at which the block reports full; must equal 2^CNT_W-1.

Ports:
- w_clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req_add  input  1  level request to increment; hold until ack_add or nak_add.
- req_rem  input  1  level request to decrement; hold until ack_rem or nak_rem.
- ack_add  output  1  one-cycle pulse: increment completed.
- ack_rem  output  1  one-cycle pulse: decrement completed.
- nak_add  output  1  one-cycle pulse: add refused (full).
- nak_rem  output  1  one-cycle pulse: remove refused (empty).
- cnt_x  output  1  direction to counter X (1=up, 0=down).
- cnt_p  output  1  step enable to counter P.
- cnt_q  input  CNT_W  counter Q feedback.
- count  output  CNT_W  shadow count.
- full  output  1  count==MAX_COUNT.
- empty  output  1  count==0.
- busy  output  1  FSM not in IDLE.
- err  output  1  sticky; set when feedback disagrees with shadow.

Behaviour:
- Reset values:
  - state=IDLE, count=0, all ack/nak=0, cnt_x=0, cnt_p=0, busy=0, err=0.
  - full=0 and empty=1 (combinational from count).
  - last_grant=REM, so the first tie goes to add.
- All outputs are registered except full and empty.
- FSM states: IDLE, SETUP, STEP, CHECK.
- IDLE:
  - Eligibility: add_ok = req_add & !full; rem_ok = req_rem & !empty.
  - Only one eligible: grant it.
  - Both eligible: grant the side opposite last_grant (round-robin), then update last_grant.
  - On grant: load cnt_x (1 add / 0 remove), go to SETUP.
  - Not eligible: req_add while full pulses nak_add for one cycle; req_rem while empty pulses nak_rem for one cycle; stay IDLE. Both naks may pulse in the same cycle.
  - A nak-ed request still high two cycles later is nak-ed again.
- SETUP: cnt_x held stable (setup for the gated counter clock); cnt_p=0; go to STEP.
- STEP:
  - cnt_p=1 for exactly this one cycle; cnt_x held.
  - Shadow count updates +1 (add) or -1 (remove) on exit.
  - Go to CHECK.
- CHECK:
  - cnt_p=0.
  - Compare cnt_q with count; mismatch sets err.
  - Pulse the granted ack on the transition to IDLE.
  - Return to IDLE.
- Timing:
  - Grant at edge n; ack high in the cycle after edge n+3, i.e. 4 cycles from request sample to ack.
  - Throughput: one step per 4 cycles.
- Requester rules:
  - A request is sampled only in IDLE.
  - A requester still asserting in the cycle ack is high is treated as a new request on the next IDLE evaluation.
  - Requests changing while busy are ignored until IDLE.
- Arithmetic:
  - Shadow count never wraps: the add path is unreachable at MAX_COUNT, the remove path unreachable at 0.
  - cnt_p is never asserted with X=1 at 7 or X=0 at 0.
- Reset mid-operation (any state): immediate return to reset values; no ack issued for the aborted step; cnt_p drops asynchronously.
- err clears only on reset.

Optional Feature:
- Macro: LOAD_RESYNC_EN.
- Defined: on a CHECK mismatch, err is still set and count is reloaded from cnt_q at the same edge. Arbitration then continues using the counter's actual value.
- Undefined: count is not modified on a mismatch; only err is set.

Test Plan:
- Reset, then req_add held for 7 transactions (drop on ack) -> 7 ack_add pulses 4 cycles apart; count=7; full=1; cnt_p high exactly 7 single cycles; err=0.
- At count=7, req_add=1 -> nak_add pulses 1 cycle, no cnt_p, count stays 7; then req_rem -> ack_rem, count=6.
- At count=3, req_add and req_rem both held continuously -> grants alternate add, rem, add, rem; count sequence 4,3,4,3.
- From reset (empty), req_rem=1 -> nak_rem, count=0, no cnt_p. Then req_add and req_rem held together -> add granted first (last_grant=REM); count=1 after 4 cycles.
- Assert reset during STEP at count=2 -> count=0, busy=0, cnt_p=0 immediately, no ack pulse.
- Force cnt_q=5 while shadow=3 in CHECK -> err=1 and stays 1. With LOAD_RESYNC_EN: count=5 next cycle. Without it: count stays 3.
